// File: rtl/id_regfile.sv
// id_regfile -- decode-stage register file with forwarding and load-use stall.
//
// Purpose:
//   32 x 32-bit integer register file (r0 hard-wired to zero) with two
//   combinational read ports. Each read port forwards pending results from
//   the EX, MEM and WB stages, youngest first. WB data is also bypassed in
//   the same cycle it is written. A read that hits a load still in EX cannot
//   be satisfied, so the block raises stall_req and drives that port to zero.
//
// Ports:
//   clk                     rising-edge clock for all state
//   rst                     synchronous, active-high reset
//   wb_wd/wb_reg/wb_wdata   write-back index / enable / data
//   ex_wd/ex_reg/ex_wdata   EX-stage pending result (index / valid / data)
//   ex_is_load              EX-stage result is a load (data not yet valid)
//   mem_wd/mem_reg/mem_wdata MEM-stage pending result (index / valid / data)
//   re1/re2                 read-port enables
//   raddr1/raddr2           read-port indices
//   rdata1/rdata2           read-port data (combinational)
//   stall_req               load-use hazard on either port (combinational)

// ---------------------------------------------------------------------------
// One read port: source selection and hazard detection.
// ---------------------------------------------------------------------------
module id_rf_rdport (
    input  logic        rst,
    input  logic        re,
    input  logic [4:0]  raddr,
    input  logic [31:0] arr_data,
    input  logic [4:0]  ex_wd,
    input  logic        ex_reg,
    input  logic        ex_is_load,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  mem_wd,
    input  logic        mem_reg,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  wb_wd,
    input  logic        wb_reg,
    input  logic [31:0] wb_wdata,
    output logic [31:0] rdata,
    output logic        hazard
);
    logic active;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        // raddr != 0 inside 'active' means a stage with index 0 can never
        // match, so no separate zero-index check is needed per stage.
        active  = !rst && re && (raddr != 5'd0);
        ex_hit  = active && ex_reg  && (ex_wd  == raddr);
        mem_hit = active && mem_reg && (mem_wd == raddr);
        wb_hit  = active && wb_reg  && (wb_wd  == raddr);
        hazard  = ex_hit && ex_is_load;

        rdata = '0;
        // A load in EX is the youngest producer; older copies in MEM/WB or
        // the array are stale, so the port returns zero while stalled.
        if (!active || hazard) rdata = '0;
        else if (ex_hit)       rdata = ex_wdata;
        else if (mem_hit)      rdata = mem_wdata;
        else if (wb_hit)       rdata = wb_wdata;
        else                   rdata = arr_data;
    end
endmodule

// ---------------------------------------------------------------------------
// Top level.
// ---------------------------------------------------------------------------
module id_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_reg,
    input  logic [31:0] wb_wdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_reg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_wd,
    input  logic        mem_reg,
    input  logic [31:0] mem_wdata,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        stall_req
);
    localparam int NUM_RD = 2;

    logic [31:0] regs [32];

    logic [NUM_RD-1:0]       re_v;
    logic [NUM_RD-1:0][4:0]  raddr_v;
    logic [NUM_RD-1:0][31:0] arr_v;
    logic [NUM_RD-1:0][31:0] rdata_v;
    logic [NUM_RD-1:0]       hazard_v;

    assign re_v    = {re2, re1};
    assign raddr_v = {raddr2, raddr1};

    // Storage. r0 is never written, so it stays zero after reset; the read
    // ports additionally force zero for index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_reg && (wb_wd != 5'd0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign arr_v[p] = regs[raddr_v[p]];

        id_rf_rdport u_port (
            .rst       (rst),
            .re        (re_v[p]),
            .raddr     (raddr_v[p]),
            .arr_data  (arr_v[p]),
            .ex_wd     (ex_wd),
            .ex_reg    (ex_reg),
            .ex_is_load(ex_is_load),
            .ex_wdata  (ex_wdata),
            .mem_wd    (mem_wd),
            .mem_reg   (mem_reg),
            .mem_wdata (mem_wdata),
            .wb_wd     (wb_wd),
            .wb_reg    (wb_reg),
            .wb_wdata  (wb_wdata),
            .rdata     (rdata_v[p]),
            .hazard    (hazard_v[p])
        );
    end

    assign rdata1    = rdata_v[0];
    assign rdata2    = rdata_v[1];
    assign stall_req = |hazard_v;
endmodule

// File: tb/tb_id_regfile.sv
// Bench for id_regfile: directed vectors, a behavioural model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_id_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd, ex_wd, mem_wd, raddr1, raddr2;
    logic        wb_reg, ex_reg, ex_is_load, mem_reg, re1, re2;
    logic [31:0] wb_wdata, ex_wdata, mem_wdata;
    logic [31:0] rdata1, rdata2;
    logic        stall_req;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    id_regfile dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_reg(wb_reg), .wb_wdata(wb_wdata),
        .ex_wd(ex_wd), .ex_reg(ex_reg), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_wd(mem_wd), .mem_reg(mem_reg), .mem_wdata(mem_wdata),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .stall_req(stall_req)
    );

    // Architectural register state as seen by software.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (wb_reg && wb_wd != 5'd0) begin
            model[wb_wd] <= wb_wdata;
        end
    end

    // Pending producers listed youngest first; the first one naming the
    // register supplies the value, a load in EX supplies nothing.
    function automatic logic [31:0] mdl_read(input logic en, input logic [4:0] a);
        logic [4:0]  idx [3];
        logic        vld [3];
        logic [31:0] dat [3];
        if (rst || !en || a == 5'd0) return 32'h0;
        idx[0] = ex_wd;  vld[0] = ex_reg;  dat[0] = ex_wdata;
        idx[1] = mem_wd; vld[1] = mem_reg; dat[1] = mem_wdata;
        idx[2] = wb_wd;  vld[2] = wb_reg;  dat[2] = wb_wdata;
        for (int s = 0; s < 3; s++) begin
            if (vld[s] && idx[s] == a) begin
                if (s == 0 && ex_is_load) return 32'h0;
                return dat[s];
            end
        end
        return model[a];
    endfunction

    function automatic logic mdl_stall();
        logic h1, h2;
        h1 = re1 && raddr1 != 5'd0 && ex_wd == raddr1;
        h2 = re2 && raddr2 != 5'd0 && ex_wd == raddr2;
        return !rst && ex_reg && ex_is_load && (h1 || h2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("model_rdata1", rdata1, mdl_read(re1, raddr1));
            chk("model_rdata2", rdata2, mdl_read(re2, raddr2));
            chk("model_stall", {31'h0, stall_req}, {31'h0, mdl_stall()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_wd = 0;  wb_reg = 0;  wb_wdata = 0;
        ex_wd = 0;  ex_reg = 0;  ex_wdata = 0;  ex_is_load = 0;
        mem_wd = 0; mem_reg = 0; mem_wdata = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_wd = a; wb_reg = 1; wb_wdata = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        re1 = 1; re2 = 1; raddr1 = a1; raddr2 = a2;
    endtask

    logic [4:0]  tbl_a [4] = '{5'd1, 5'd2, 5'd30, 5'd31};
    logic [31:0] tbl_d [4] = '{32'h0000_0011, 32'hA5A5_5A5A, 32'h8000_0001, 32'hFFFF_FFFF};

    initial begin
        idle();
        rst = 1;
        // Reset dominates: pending load hazard and WB write are ignored.
        ex_reg = 1; ex_is_load = 1; ex_wd = 5; ex_wdata = 32'h77;
        wb(5, 32'h99);
        rd(5, 5);
        tick();
        armed = 1'b1;
        @(negedge clk);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        tick();
        idle();
        rst = 0;

        // All registers read zero after reset.
        for (int i = 1; i < 32; i++) begin
            rd(i[4:0], 5'(32 - i));
            @(negedge clk);
            chk("post_rst_r1", rdata1, 32'h0);
            chk("post_rst_r2", rdata2, 32'h0);
            chk("post_rst_stall", {31'h0, stall_req}, 32'h0);
            tick();
        end
        idle();

        // Same-cycle WB bypass, then array read.
        wb(5, 32'hDEADBEEF); re1 = 1; raddr1 = 5;
        @(negedge clk);
        chk("wb_bypass", rdata1, 32'hDEADBEEF);
        tick();
        idle(); re1 = 1; raddr1 = 5;
        @(negedge clk);
        chk("wb_array", rdata1, 32'hDEADBEEF);
        tick();

        // r0 ignores writes.
        idle(); wb(0, 32'h12345678); rd(0, 0);
        @(negedge clk);
        chk("r0_same", rdata1, 32'h0);
        tick();
        idle(); rd(0, 0);
        @(negedge clk);
        chk("r0_next", rdata2, 32'h0);
        tick();

        // Forwarding priority on r7.
        idle(); wb(7, 32'h1);
        tick();
        wb(7, 32'h2); mem_reg = 1; mem_wd = 7; mem_wdata = 32'h3;
        ex_reg = 1; ex_wd = 7; ex_wdata = 32'h4; rd(7, 7);
        @(negedge clk);
        chk("prio_ex1", rdata1, 32'h4);
        chk("prio_ex2", rdata2, 32'h4);
        tick();
        ex_reg = 0;
        @(negedge clk);
        chk("prio_mem", rdata1, 32'h3);
        tick();
        mem_reg = 0;
        @(negedge clk);
        chk("prio_wb", rdata2, 32'h2);
        tick();

        // Load-use hazard on port 1, port 2 forwards from MEM.
        idle(); ex_reg = 1; ex_is_load = 1; ex_wd = 9; ex_wdata = 32'hBAD;
        mem_reg = 1; mem_wd = 4; mem_wdata = 32'hAA; rd(9, 4);
        @(negedge clk);
        chk("lu_stall", {31'h0, stall_req}, 32'h1);
        chk("lu_rdata1", rdata1, 32'h0);
        chk("lu_rdata2", rdata2, 32'hAA);
        tick();
        re1 = 0;
        @(negedge clk);
        chk("lu_clear", {31'h0, stall_req}, 32'h0);
        tick();
        // Hazard on port 2 only; load in EX hides an older MEM copy.
        raddr2 = 9; mem_wd = 9; re1 = 1; raddr1 = 4;
        @(negedge clk);
        chk("lu_p2_stall", {31'h0, stall_req}, 32'h1);
        chk("lu_p2_rdata2", rdata2, 32'h0);
        tick();

        // Index-0 producers never stall or forward.
        idle(); ex_reg = 1; ex_is_load = 1; ex_wd = 0; mem_reg = 1; mem_wd = 0;
        mem_wdata = 32'hCC; rd(0, 5);
        @(negedge clk);
        chk("zero_stall", {31'h0, stall_req}, 32'h0);
        chk("zero_fwd", rdata2, 32'hDEADBEEF);
        tick();

        // Disabled port stays zero even with a matching producer.
        idle(); ex_reg = 1; ex_wd = 5; ex_wdata = 32'h1234; re1 = 0; raddr1 = 5;
        re2 = 1; raddr2 = 5;
        @(negedge clk);
        chk("ren_off", rdata1, 32'h0);
        chk("ren_on", rdata2, 32'h1234);
        tick();

        // Table of writes, then read back in pairs.
        idle();
        for (int i = 0; i < 4; i++) begin
            wb(tbl_a[i], tbl_d[i]);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd(tbl_a[i], tbl_a[3 - i]);
            @(negedge clk);
            chk("tbl_p1", rdata1, tbl_d[i]);
            chk("tbl_p2", rdata2, tbl_d[3 - i]);
            tick();
        end

        // Reset mid-operation discards concurrent WB and clears the array.
        idle(); wb(3, 32'h55);
        tick();
        wb(3, 32'h66); rst = 1; mem_reg = 1; mem_wd = 3; mem_wdata = 32'h77;
        tick();
        idle(); rst = 0; rd(3, 5);
        @(negedge clk);
        chk("rst_mid_r3", rdata1, 32'h0);
        chk("rst_mid_r5", rdata2, 32'h0);
        tick();

        idle();
        tick();
        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_regfile.md
ID_REGFILE -- requirements
Module: id_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wb_wd  input  5  write-back destination register index.
REQ-005 wb_reg  input  1  write-back write enable.
REQ-006 wb_wdata  input  32  write-back data.
REQ-007 ex_wd / ex_reg / ex_wdata  input  5/1/32  EX-stage pending result (index, valid, data).
REQ-008 ex_is_load  input  1  EX-stage instruction is a load; ex_wdata not yet valid.
REQ-009 mem_wd / mem_reg / mem_wdata  input  5/1/32  MEM-stage pending result (index, valid, data).
REQ-010 re1, re2  input  1  read-port enables.
REQ-011 raddr1, raddr2  input  5  read-port register indices.
REQ-012 rdata1, rdata2  output  32  read-port data, combinational.
REQ-013 stall_req  output  1  load-use hazard; ID stage must hold, combinational.

Function
REQ-014 Storage SHALL be 32 x 32-bit registers; index 0 reads 0 at all times and is never written.
REQ-015 Write: at rising clk with rst=0, wb_reg=1, wb_wd!=0 -> reg[wb_wd] <= wb_wdata; otherwise no change.
REQ-016 Read port n SHALL output 0 when rst=1, ren=0, or raddrn=0.
REQ-017 Otherwise, source priority per port, first match wins: EX (ex_reg=1 and ex_wd=raddrn and ex_is_load=0) -> ex_wdata; MEM (mem_reg=1, mem_wd=raddrn) -> mem_wdata; WB (wb_reg=1, wb_wd=raddrn) -> wb_wdata (same-cycle write bypass); else reg[raddrn].
REQ-018 Youngest result wins: EX over MEM over WB when several match the same index.
REQ-019 Load-use: stall_req=1 when rst=0 and, for either port n, ren=1, raddrn!=0, ex_reg=1, ex_is_load=1, ex_wd=raddrn.
REQ-020 A port in load-use hazard SHALL output 0 (no fall-through to MEM/WB/array); the other port forwards normally.
REQ-021 Forwarding/stall SHALL ignore any stage whose index is 0, even with its enable set.
REQ-022 Reads and stall_req SHALL be purely combinational (zero latency); writes take effect at the next rising clk and are visible the same cycle via REQ-017 bypass.
REQ-023 Write and read to the same index in the same cycle: read returns new data (bypass); array updated at edge.
REQ-024 Both ports may address the same register; each resolves independently and identically.

Reset
REQ-025 While rst=1 at a rising clk, all 32 registers SHALL be cleared to 0 and any concurrent WB write discarded.
REQ-026 While rst=1, rdata1=rdata2=0 and stall_req=0 regardless of other inputs.
REQ-027 Reset asserted mid-operation (pending EX/MEM/WB results) SHALL leave no residual state; first post-reset read of any register returns 0 unless bypassed.

Verification
REQ-028 Reset, then read r1..r31 on both ports with no stage matching -> all 0, stall_req=0.
REQ-029 WB write r5=0xDEADBEEF; same cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF; next cycle, WB idle -> rdata1=0xDEADBEEF from array.
REQ-030 WB write r0=0x12345678 with wb_reg=1; read r0 same and next cycle -> 0.
REQ-031 reg[7]=0x1, WB r7=0x2, MEM r7=0x3, EX r7=0x4 (non-load); raddr1=raddr2=7 -> both 0x4; drop EX -> 0x3; drop MEM -> 0x2.
REQ-032 ex_is_load=1, ex_reg=1, ex_wd=9; raddr1=9, re1=1; raddr2=4, MEM r4=0xAA -> stall_req=1, rdata1=0, rdata2=0xAA; re1=0 -> stall_req=0.
REQ-033 Write r3=0x55 then assert rst one cycle while WB writes r3=0x66 -> after reset, read r3 -> 0.
